// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and widths for the hazard scheduler
package hazard_pkg;
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_STALL  = 2'd1,
    ST_IMEM_WAIT = 2'd2,
    ST_FLUSH     = 2'd3
  } state_t;
  localparam int DEF_REG_AW = 5;
  localparam int CNT_W = 3;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use compare between the load in EX and the sources in ID
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              mem_read,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              lu
);
  assign lu = mem_read && (rd != '0) && (rd == rs || rd == rt);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush scheduler for the pipeline front end; HAZARD_STATS_EN adds stall/flush cycle counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int REG_AW            = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic              redirect,
  input  logic              imem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        hz_state
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_cycles
`endif
);
  localparam logic [CNT_W-1:0] LU_LOAD = CNT_W'(LOAD_STALL_CYCLES > 1 ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] FL_LOAD = CNT_W'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic lu, run_mode;
  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .mem_read(idex_mem_read),
    .rd      (idex_rt),
    .rs      (id_rs),
    .rt      (id_rt),
    .lu      (lu)
  );
  // The cycle the fetch returns decides like RUN so a hazard arriving then is not lost
  assign run_mode = (state == ST_RUN) || (state == ST_IMEM_WAIT && !imem_busy);
  assign hz_state = state;
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (run_mode) begin
      state_n = ST_RUN;
      if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_n     = LOAD_STALL_CYCLES > 1 ? ST_LU_STALL : ST_RUN;
        cnt_n       = LU_LOAD;
      end else if (redirect) begin
        ifid_flush  = 1'b1;
        idex_bubble = FLUSH_CYCLES >= 2;
        state_n     = FLUSH_CYCLES > 1 ? ST_FLUSH : ST_RUN;
        cnt_n       = FL_LOAD;
      end else if (imem_busy) begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
        state_n    = ST_IMEM_WAIT;
      end
    end else begin
      case (state)
        ST_LU_STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_n     = cnt == '0 ? ST_RUN : ST_LU_STALL;
          cnt_n       = cnt == '0 ? cnt : cnt - 1'b1;
        end
        ST_IMEM_WAIT: begin
          pc_write   = redirect;
          ifid_flush = 1'b1;
        end
        ST_FLUSH: begin
          pc_write    = !imem_busy;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_n     = (!redirect && cnt == '0) ? ST_RUN : ST_FLUSH;
          cnt_n       = redirect ? FL_LOAD : (cnt == '0 ? cnt : cnt - 1'b1);
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!ifid_write && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 1'b1;
      if (ifid_flush && flush_cycles != 16'hFFFF) flush_cycles <= flush_cycles + 1'b1;
    end
  end
`endif
endmodule
